// File: rtl/s2p_deserializer.sv
// ---------------------------------------------------------------------------
// s2p_deserializer
//
// Serial-to-parallel converter. A qualified serial bit stream is shifted into
// WIDTH-bit words, in MSB-first or LSB-first order. An optional even-parity
// bit can follow each word. Completed words are offered on a valid/ready port
// backed by a single holding register. A word that completes while that
// register is still occupied is dropped and flagged with a sticky overrun bit.
//
// Parameters
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: first received bit lands in bit WIDTH-1, 0: in bit 0
//   PARITY_EN  1: an even-parity bit follows the WIDTH data bits
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   ser_valid    qualifies ser_data / frame_start
//   ser_data     serial data bit
//   frame_start  marks the accepted bit as the first data bit of a word
//                (also resynchronises a word in progress)
//   par_ready    downstream accepts par_data
//   clr_overrun  clears the sticky overrun flag (a new overrun wins)
//   par_data     assembled word, stable while par_valid=1
//   par_valid    holding register contains an unconsumed word
//   parity_err   parity result for par_data (always 0 when PARITY_EN=0)
//   overrun      sticky: a completed word was dropped
//   bit_cnt      data bits accumulated in the current word
// ---------------------------------------------------------------------------
module s2p_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ser_valid,
    input  logic                         ser_data,
    input  logic                         frame_start,
    input  logic                         par_ready,
    input  logic                         clr_overrun,
    output logic [WIDTH-1:0]             par_data,
    output logic                         par_valid,
    output logic                         parity_err,
    output logic                         overrun,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Place one new bit into the word. After WIDTH calls the first bit sits
    // in bit WIDTH-1 (MSB_FIRST) or bit 0 (LSB first); older content is
    // shifted out entirely, so the register never needs clearing between
    // words.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                   input logic             b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {word[WIDTH-2:0], b};
        end else begin
            res = {b, word[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Even parity: the XOR of all data bits and the parity bit must be 0.
    // A result of 1 therefore flags an error.
    function automatic logic even_parity_err(input logic [WIDTH-1:0] word,
                                             input logic             pbit);
        return (^word) ^ pbit;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [WIDTH-1:0] word_p0;
    logic             perr_p0;
    logic             vld_p0;
    logic             load_p0;
    logic             drop_p0;

    // ---- stage 0: bit acceptance, framing and word assembly ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        word_p0   = shreg;
        perr_p0   = 1'b0;
        vld_p0    = 1'b0;

        if (ser_valid) begin
            if (frame_start) begin
                // A framed bit always starts a fresh word. In DATA or PAR
                // this silently abandons the partial word (resync).
                state_nxt = DATA;
                shreg_nxt = shift_in('0, ser_data);
                cnt_nxt   = CNT_ONE;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Unframed bits before the first frame_start are noise.
                    end
                    DATA: begin
                        shreg_nxt = shift_in(shreg, ser_data);
                        if (bit_cnt == CNT_LAST) begin
                            if (PARITY_EN) begin
                                // Hold the full count while the parity bit
                                // is outstanding.
                                state_nxt = PAR;
                                cnt_nxt   = CNT_FULL;
                            end else begin
                                cnt_nxt = '0;
                                word_p0 = shreg_nxt;
                                vld_p0  = 1'b1;
                            end
                        end else begin
                            cnt_nxt = bit_cnt + CNT_ONE;
                        end
                    end
                    PAR: begin
                        // The parity bit is not shifted in; the word is
                        // already complete in the shift register.
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                        word_p0   = shreg;
                        perr_p0   = even_parity_err(shreg, ser_data);
                        vld_p0    = 1'b1;
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // A completed word is loaded when the holding register is free or is
    // being emptied in this same cycle; otherwise the new word is lost.
    assign load_p0 = vld_p0 && (!par_valid || par_ready);
    assign drop_p0 = vld_p0 && par_valid && !par_ready;

    // ---- stage 1: output holding register and overrun flag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            par_data   <= '0;
            parity_err <= 1'b0;
            par_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_p0) begin
                par_data   <= word_p0;
                parity_err <= perr_p0;
                par_valid  <= 1'b1;
            end else if (par_valid && par_ready) begin
                // Transfer only; par_data/parity_err keep their value.
                par_valid <= 1'b0;
            end

            // A fresh drop takes priority over a simultaneous clear.
            if (drop_p0) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_deserializer.sv
// ---------------------------------------------------------------------------
// tb_s2p_deserializer
//
// Three instances share one stimulus stream:
//   0: WIDTH=8, MSB first, no parity
//   1: WIDTH=8, LSB first, no parity
//   2: WIDTH=8, MSB first, even parity
// A list-of-bits reference model per instance predicts every output after
// every clock; directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_s2p_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ser_valid, ser_data, frame_start, par_ready, clr_overrun;

    logic [7:0] dat  [3];
    logic       vld  [3];
    logic       perr [3];
    logic       ovr  [3];
    logic [3:0] cnt  [3];

    s2p_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
        .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
        .frame_start(frame_start), .par_ready(par_ready), .clr_overrun(clr_overrun),
        .par_data(dat[0]), .par_valid(vld[0]), .parity_err(perr[0]),
        .overrun(ovr[0]), .bit_cnt(cnt[0]));

    s2p_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
        .frame_start(frame_start), .par_ready(par_ready), .clr_overrun(clr_overrun),
        .par_data(dat[1]), .par_valid(vld[1]), .parity_err(perr[1]),
        .overrun(ovr[1]), .bit_cnt(cnt[1]));

    s2p_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
        .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data),
        .frame_start(frame_start), .par_ready(par_ready), .clr_overrun(clr_overrun),
        .par_data(dat[2]), .par_valid(vld[2]), .parity_err(perr[2]),
        .overrun(ovr[2]), .bit_cnt(cnt[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the bits of the current word in arrival order.
    bit         m_msb [3] = '{1'b1, 1'b0, 1'b1};
    bit         m_pen [3] = '{1'b0, 1'b0, 1'b1};
    bit         m_bits[3][9];
    int         m_n   [3];
    bit         m_in  [3];
    logic [7:0] m_dat [3];
    bit         m_vld [3];
    bit         m_pe  [3];
    bit         m_ovr [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit v, input bit d,
                              input bit fs, input bit rdy, input bit clr);
        bit done, drop, pe;
        int val, ones;
        done = 1'b0;
        pe   = 1'b0;
        val  = 0;
        if (r) begin
            m_in[k] = 1'b0; m_n[k] = 0; m_dat[k] = '0;
            m_vld[k] = 1'b0; m_pe[k] = 1'b0; m_ovr[k] = 1'b0;
            return;
        end
        if (v) begin
            if (fs) begin
                m_in[k] = 1'b1;
                m_bits[k][0] = d;
                m_n[k] = 1;
            end else if (m_in[k]) begin
                m_bits[k][m_n[k]] = d;
                m_n[k]++;
            end
            if (m_in[k] && m_n[k] == 8 + int'(m_pen[k])) begin
                done = 1'b1;
                ones = 0;
                for (int i = 0; i < 8; i++) begin
                    if (m_msb[k]) val = val * 2 + int'(m_bits[k][i]);
                    else          val = val + (int'(m_bits[k][i]) << i);
                end
                for (int i = 0; i < 8 + int'(m_pen[k]); i++) ones += int'(m_bits[k][i]);
                pe = m_pen[k] && (ones % 2 == 1);
                m_n[k] = 0;
            end
        end
        drop = done && m_vld[k] && !rdy;
        if (drop) m_ovr[k] = 1'b1;
        else if (clr) m_ovr[k] = 1'b0;
        if (done && !drop) begin
            m_dat[k] = 8'(val);
            m_pe[k]  = pe;
            m_vld[k] = 1'b1;
        end else if (m_vld[k] && rdy) begin
            m_vld[k] = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit fs,
                        input bit rdy, input bit clr);
        rst = r; ser_valid = v; ser_data = d; frame_start = fs;
        par_ready = rdy; clr_overrun = clr;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, v, d, fs, rdy, clr);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d.par_data", k),   32'(dat[k]),  32'(m_dat[k]));
            check($sformatf("dut%0d.par_valid", k),  32'(vld[k]),  32'(m_vld[k]));
            check($sformatf("dut%0d.parity_err", k), 32'(perr[k]), 32'(m_pe[k]));
            check($sformatf("dut%0d.overrun", k),    32'(ovr[k]),  32'(m_ovr[k]));
            check($sformatf("dut%0d.bit_cnt", k),    32'(cnt[k]),  32'(m_n[k]));
        end
    endtask

    // Send n bits of pat, most significant of the n first.
    task automatic send_stream(input logic [31:0] pat, input int n, input bit frame, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, pat[n-1-i], frame && (i == 0), rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        int bias;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_data", 32'(dat[0]), 32'h0);
        check("rst_valid", 32'(vld[0]), 32'h0);
        check("rst_overrun", 32'(ovr[0]), 32'h0);
        check("rst_cnt", 32'(cnt[2]), 32'h0);

        // Unframed bits after reset are discarded
        send_stream(32'hFF, 8, 1'b0, 1'b1);
        check("idle_noise_valid", 32'(vld[0]), 32'h0);

        // Basic word, both bit orders
        send_stream(32'hC1, 8, 1'b1, 1'b1);
        check("msb_word", 32'(dat[0]), 32'hC1);
        check("msb_valid", 32'(vld[0]), 32'h1);
        check("lsb_word", 32'(dat[1]), 32'h83);
        check("msb_perr", 32'(perr[0]), 32'h0);

        // Parity: good parity bit, then bad parity bit
        send_stream(32'h1, 1, 1'b0, 1'b1);
        check("par_ok_data", 32'(dat[2]), 32'hC1);
        check("par_ok_valid", 32'(vld[2]), 32'h1);
        check("par_ok_err", 32'(perr[2]), 32'h0);
        send_stream(32'h182, 9, 1'b1, 1'b1);
        check("par_bad_data", 32'(dat[2]), 32'hC1);
        check("par_bad_err", 32'(perr[2]), 32'h1);

        // Gaps mid-word hold bit_cnt
        send_stream(32'hF, 4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("gap_cnt", 32'(cnt[1]), 32'h4);
        end
        send_stream(32'hF, 4, 1'b0, 1'b1);
        check("gap_word", 32'(dat[1]), 32'hFF);
        send_stream(32'h0, 1, 1'b0, 1'b1);
        check("gap_par_word", 32'(dat[2]), 32'hFF);
        check("gap_par_err", 32'(perr[2]), 32'h0);

        // Overrun with par_ready low, clear, then drain
        send_stream(32'h11, 8, 1'b1, 1'b0);
        send_stream(32'h22, 8, 1'b0, 1'b0);
        check("ovr_hold_data", 32'(dat[0]), 32'h11);
        check("ovr_set", 32'(ovr[0]), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clear", 32'(ovr[0]), 32'h0);
        check("ovr_still_valid", 32'(vld[0]), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_valid", 32'(vld[0]), 32'h0);
        check("drain_data_kept", 32'(dat[0]), 32'h11);

        // Resync: partial word abandoned by a new frame_start
        send_stream(32'h1B, 5, 1'b1, 1'b1);
        check("partial_no_valid", 32'(vld[0]), 32'h0);
        send_stream(32'hA5, 8, 1'b1, 1'b1);
        check("resync_word", 32'(dat[0]), 32'hA5);
        check("resync_no_ovr", 32'(ovr[0]), 32'h0);

        // Reset mid-word, then unframed bits are ignored
        send_stream(32'hA, 4, 1'b1, 1'b1);
        check("pre_rst_cnt", 32'(cnt[0]), 32'h4);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("midrst_data", 32'(dat[0]), 32'h0);
        check("midrst_cnt", 32'(cnt[0]), 32'h0);
        check("midrst_valid", 32'(vld[0]), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            check("post_rst_cnt", 32'(cnt[0]), 32'h0);
        end

        // Continuous stream of three words with a single frame_start
        pat = 32'h010203;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, pat[23-i], i == 0, 1'b1, 1'b0);
            if (i % 8 == 7) begin
                check("stream_word", 32'(dat[0]), 32'(i / 8 + 1));
                check("stream_valid", 32'(vld[0]), 32'h1);
            end else begin
                check("stream_gap_valid", 32'(vld[0]), 32'h0);
            end
        end

        // Randomised traffic with varying backpressure
        bias = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) bias = $urandom_range(2, 10);
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < bias,
                 $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
